parity_stream: RTL and testbench

PARITY_STREAM -- requirements
Module: parity_stream

---
 rtl/parity_stream.sv | 128 ++++++++++++
 tb/tb_parity_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream.sv
// parity_stream: one-deep registered parity stage on a valid/ready stream.
// MODE=0 generates the parity bit for each beat. MODE=1 also compares it
// against the received IN_PAR and flags any mismatch on OUT_ERR.
// The output register refills in the same cycle it drains, so a continuous
// stream passes through at one beat per clock with exactly one cycle of latency.
// Optional feature: define PARITY_ERR_CNT_EN to add the ERR_CNT port and a
// 16-bit saturating mismatch counter that ERR_CLR clears.
// Reset is synchronous and active-high on RST.

module parity_stream #(
  parameter int WIDTH = 8,  // data word width, 2..64
  parameter int ODD   = 1   // 1: odd parity, 0: even parity
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_PAR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_PAR,
  output logic             OUT_ERR,
  input  logic             ERR_CLR
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [15:0]      ERR_CNT
`endif
);

  // Two-state occupancy of the single output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;

  logic odd_sel;   // parity sense as a single bit
  logic par;       // parity of the word currently presented on IN_DATA
  logic mismatch;  // check-mode mismatch for the presented word
  logic accept;    // a beat transfers into the output register this cycle

  assign odd_sel  = (ODD != 0);

  // Reducing XOR counts the ones; XOR with odd_sel makes data plus par
  // hold an odd number of ones for odd parity and an even number for even.
  assign par      = (^IN_DATA) ^ odd_sel;
  assign mismatch = MODE && (IN_PAR != par);

  // Ready whenever the register is empty or is being drained this cycle.
  // Taking a new beat in the same cycle the old one leaves gives full
  // throughput without a skid buffer.
  assign IN_READY  = (state == EMPTY) || OUT_READY;
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (state == FULL);

  // Occupancy control and output register: load on accept, hold otherwise.
  always_ff @(posedge CLK) begin
    // NOTE: every register in a clocked block is assigned with <=, so all of
    // them sample pre-edge values and the order of the statements below does
    // not matter. A blocking = here would let a later statement see a value
    // updated earlier in the same edge.
    if (RST) begin
      // Reset takes priority over any handshake in the same cycle, so a beat
      // in flight is discarded and no new beat is taken.
      state    <= EMPTY;
      OUT_DATA <= '0;
      OUT_PAR  <= 1'b0;
      OUT_ERR  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          // Stay FULL on backpressure or on drain-and-refill.
          if (OUT_READY && !accept) begin
            state <= EMPTY;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase

      // Payload moves only on accept. Under backpressure IN_READY is low, so
      // the beat being presented downstream stays stable, and IN_DATA,
      // IN_PAR and MODE are ignored.
      if (accept) begin
        OUT_DATA <= IN_DATA;
        OUT_PAR  <= par;
        OUT_ERR  <= mismatch;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN

  logic count_err;  // an accepted beat carries a check-mode mismatch

  assign count_err = accept && mismatch;

  // Saturating mismatch counter. A clear wins over a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_CNT <= 16'd0;
    end else if (ERR_CLR) begin
      ERR_CNT <= 16'd0;
    end else if (count_err && (ERR_CNT != 16'hFFFF)) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end
  end

`else

  // Without the counter ERR_CLR has no function. The port stays on the block
  // so that both builds share one pin list apart from ERR_CNT.
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;

`endif

endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream: directed self-checking bench for parity_stream with
// WIDTH=8 and ODD=1. Every expected parity value is hand-computed: P is 1 when
// the data byte has an even number of ones. Inputs change 1 ns after a rising
// edge, and outputs are sampled at the same point, well clear of the edge.
// Checks on the error counter are compiled in only when PARITY_ERR_CNT_EN is
// defined, which matches the DUT build.

module tb_parity_stream;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             MODE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_PAR;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_PAR;
  logic             OUT_ERR;
  logic             ERR_CLR;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0]      ERR_CNT;
`endif

  int checks = 0;
  int errors = 0;

  parity_stream #(
    .WIDTH (WIDTH),
    .ODD   (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_PAR    (IN_PAR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_PAR   (OUT_PAR),
    .OUT_ERR   (OUT_ERR),
    .ERR_CLR   (ERR_CLR)
`ifdef PARITY_ERR_CNT_EN
    ,
    .ERR_CNT   (ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic p);
    IN_VALID = v;
    IN_DATA  = d;
    MODE     = m;
    IN_PAR   = p;
  endtask

  // Streaming vectors: data byte and its hand-computed odd parity bit.
  logic [7:0] s_data [10] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h55,
                              8'hAA, 8'h0F, 8'h10, 8'hC3, 8'h07};
  logic       s_par  [10] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,
                              1'b1,  1'b1,  1'b0,  1'b1,  1'b0};

  initial begin
    RST       = 1'b1;
    OUT_READY = 1'b1;
    ERR_CLR   = 1'b0;
    drive(1'b1, 8'hFF, 1'b1, 1'b0);  // a handshake held during reset is not taken
    #1;
    tick();
    tick();

    // Reset state.
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_out_data",  64'(OUT_DATA),  64'h00);
    check("rst_out_par",   64'(OUT_PAR),   64'd0);
    check("rst_out_err",   64'(OUT_ERR),   64'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt",   64'(ERR_CNT),   64'd0);
`endif

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(IN_READY), 64'd1);

    // Generate mode: 0x00 gives P=1 and 0x01 gives P=0, one cycle after accept.
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    check("gen0_valid", 64'(OUT_VALID), 64'd1);
    check("gen0_data",  64'(OUT_DATA),  64'h00);
    check("gen0_par",   64'(OUT_PAR),   64'd1);
    check("gen0_err",   64'(OUT_ERR),   64'd0);
    drive(1'b1, 8'h01, 1'b0, 1'b1);  // IN_PAR is ignored in generate mode
    tick();
    check("gen1_data",  64'(OUT_DATA),  64'h01);
    check("gen1_par",   64'(OUT_PAR),   64'd0);
    check("gen1_err",   64'(OUT_ERR),   64'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("gen_drain_valid", 64'(OUT_VALID), 64'd0);

    // Check mode: 0x03 has even ones, so P=1.
    drive(1'b1, 8'h03, 1'b1, 1'b1);
    tick();
    check("chk_ok_err", 64'(OUT_ERR), 64'd0);
    check("chk_ok_par", 64'(OUT_PAR), 64'd1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_ok_cnt", 64'(ERR_CNT), 64'd0);
`endif
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    tick();
    check("chk_bad_err", 64'(OUT_ERR), 64'd1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_bad_cnt", 64'(ERR_CNT), 64'd1);
`endif
    // A mismatching IN_PAR in generate mode never flags an error.
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    check("gen_mis_err", 64'(OUT_ERR), 64'd0);
`ifdef PARITY_ERR_CNT_EN
    check("gen_mis_cnt", 64'(ERR_CNT), 64'd1);
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Backpressure: 0xA5 has four ones, so P=1.
    OUT_READY = 1'b0;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h3D, 1'b1, 1'b1);  // these inputs must be ignored while stalled
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready",  64'(IN_READY),  64'd0);
      check("bp_out_valid", 64'(OUT_VALID), 64'd1);
      check("bp_out_data",  64'(OUT_DATA),  64'hA5);
      check("bp_out_par",   64'(OUT_PAR),   64'd1);
      check("bp_out_err",   64'(OUT_ERR),   64'd0);
      tick();
    end
    OUT_READY = 1'b1;
    drive(1'b1, 8'h3D, 1'b0, 1'b0);  // 0x3D has five ones, so P=0
    #1;
    check("bp_release_ready", 64'(IN_READY), 64'd1);
    tick();
    check("bp_refill_valid", 64'(OUT_VALID), 64'd1);
    check("bp_refill_data",  64'(OUT_DATA),  64'h3D);
    check("bp_refill_par",   64'(OUT_PAR),   64'd0);

    // Streaming: ten back-to-back beats, each seen one cycle after its accept.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, s_data[i], 1'b0, 1'b0);
      tick();
      check("stream_valid", 64'(OUT_VALID), 64'd1);
      check("stream_data",  64'(OUT_DATA),  64'(s_data[i]));
      check("stream_par",   64'(OUT_PAR),   64'(s_par[i]));
      check("stream_ready", 64'(IN_READY),  64'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("stream_end_valid", 64'(OUT_VALID), 64'd0);

`ifdef PARITY_ERR_CNT_EN
    // Saturation: clear the counter, preload 0xFFFE with error beats, add three more.
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("clr_cnt", 64'(ERR_CNT), 64'd0);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    repeat (65534) tick();
    check("preload_cnt", 64'(ERR_CNT), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_cnt", 64'(ERR_CNT), 64'hFFFF);
    end
    ERR_CLR = 1'b1;
    tick();
    check("clr_prio_cnt", 64'(ERR_CNT), 64'd0);
    ERR_CLR = 1'b0;
    tick();
    check("after_clr_cnt", 64'(ERR_CNT), 64'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
`endif

    // Reset mid-stream while FULL and stalled, holding an error beat.
    OUT_READY = 1'b0;
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    tick();
    check("mid_full_valid", 64'(OUT_VALID), 64'd1);
    check("mid_full_err",   64'(OUT_ERR),   64'd1);
    RST = 1'b1;
    tick();
    check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    check("mid_rst_data",  64'(OUT_DATA),  64'h00);
    check("mid_rst_err",   64'(OUT_ERR),   64'd0);
`ifdef PARITY_ERR_CNT_EN
    check("mid_rst_cnt",   64'(ERR_CNT),   64'd0);
`endif
    RST = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("mid_rel_ready", 64'(IN_READY), 64'd1);
    tick();
    check("mid_rel_valid", 64'(OUT_VALID), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
